// File: rtl/point_stream_collector.sv
// Tags per-point (x,y) updates from the core with index/frame and buffers them
// in a first-word-fall-through FIFO that feeds a valid/ready output stream.
module point_stream_collector #(
    parameter int POINTS     = 5,
    parameter int FIFO_DEPTH = 8,
    parameter int W          = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic         in_first,
    input  logic [W-1:0] in_x,
    input  logic [W-1:0] in_y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_x,
    output logic [W-1:0] out_y,
    output logic [7:0]   out_idx,
    output logic [15:0]  out_frame,
    output logic         out_last,
    output logic [15:0]  overflow_count,
    output logic         align_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [7:0] LAST_IDX = 8'(POINTS - 1);

    typedef enum logic {SYNC, CAPTURE} state_t;

    state_t         state, state_nx;
    logic [7:0]     idx, idx_nx, tag_idx;
    logic [15:0]    frame, frame_nx, tag_frame;
    logic           accept, mis_first;

    logic [W-1:0]   mem_x     [FIFO_DEPTH];
    logic [W-1:0]   mem_y     [FIFO_DEPTH];
    logic [7:0]     mem_idx   [FIFO_DEPTH];
    logic [15:0]    mem_frame [FIFO_DEPTH];
    logic [AW:0]    wr_ptr, rd_ptr;
    logic           empty, full, push, pop, drop;

    logic [W-1:0]   hold_x, hold_y;
    logic [7:0]     hold_idx;
    logic [15:0]    hold_frame;

    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        frame_nx  = frame;
        tag_idx   = idx;
        tag_frame = frame;
        accept    = 1'b0;
        mis_first = 1'b0;
        case (state)
            SYNC: begin
                if (in_valid && in_first) begin
                    accept    = 1'b1;
                    tag_idx   = '0;
                    tag_frame = '0;
                    idx_nx    = 8'd1;
                    frame_nx  = '0;
                    state_nx  = CAPTURE;
                end
            end
            CAPTURE: begin
                if (in_valid) begin
                    accept = 1'b1;
                    // Early in_first closes the partial frame and restarts at idx 0 of the next one.
                    if (in_first && idx != '0) begin
                        mis_first = 1'b1;
                        tag_idx   = '0;
                        tag_frame = frame + 16'd1;
                        idx_nx    = 8'd1;
                        frame_nx  = frame + 16'd1;
                    end else if (idx == LAST_IDX) begin
                        idx_nx   = '0;
                        frame_nx = frame + 16'd1;
                    end else begin
                        idx_nx = idx + 8'd1;
                    end
                end
            end
            default: state_nx = SYNC;
        endcase
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && out_ready;
    assign push  = accept && (!full || pop);
    assign drop  = accept && full && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= SYNC;
            idx            <= '0;
            frame          <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            overflow_count <= '0;
            align_err      <= 1'b0;
            hold_x         <= '0;
            hold_y         <= '0;
            hold_idx       <= '0;
            hold_frame     <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            frame <= frame_nx;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                hold_x     <= mem_x[rd_ptr[AW-1:0]];
                hold_y     <= mem_y[rd_ptr[AW-1:0]];
                hold_idx   <= mem_idx[rd_ptr[AW-1:0]];
                hold_frame <= mem_frame[rd_ptr[AW-1:0]];
            end
            if (drop && overflow_count != 16'hFFFF) overflow_count <= overflow_count + 16'd1;
            if (mis_first) align_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_x[wr_ptr[AW-1:0]]     <= in_x;
            mem_y[wr_ptr[AW-1:0]]     <= in_y;
            mem_idx[wr_ptr[AW-1:0]]   <= tag_idx;
            mem_frame[wr_ptr[AW-1:0]] <= tag_frame;
        end
    end

    // When empty the outputs show the last popped entry rather than stale storage.
    assign out_valid = !empty;
    assign out_x     = empty ? hold_x     : mem_x[rd_ptr[AW-1:0]];
    assign out_y     = empty ? hold_y     : mem_y[rd_ptr[AW-1:0]];
    assign out_idx   = empty ? hold_idx   : mem_idx[rd_ptr[AW-1:0]];
    assign out_frame = empty ? hold_frame : mem_frame[rd_ptr[AW-1:0]];
    assign out_last  = !empty && (mem_idx[rd_ptr[AW-1:0]] == LAST_IDX);

endmodule

// File: tb/tb_point_stream_collector.sv
// Directed bench for point_stream_collector: framing, FIFO latency/backpressure,
// overflow counting, misaligned first and reset behaviour.
module tb_point_stream_collector;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_first, out_ready;
    logic [31:0] in_x, in_y;
    logic        out_valid, out_last, align_err;
    logic [31:0] out_x, out_y;
    logic [7:0]  out_idx;
    logic [15:0] out_frame, overflow_count;

    int n_checks = 0;
    int n_fail   = 0;

    point_stream_collector #(.POINTS(5), .FIFO_DEPTH(8), .W(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_first(in_first),
        .in_x(in_x), .in_y(in_y), .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_idx(out_idx), .out_frame(out_frame),
        .out_last(out_last), .overflow_count(overflow_count), .align_err(align_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] px(input int k);
        return 32'h0001_0000 * 32'(k) + 32'h0000_0123;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic f, input logic [31:0] x, input logic [31:0] y);
        in_valid = v; in_first = f; in_x = x; in_y = y;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, '0, '0);
        tick();
        tick();
        reset = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || overflow_count !== 16'd0 || align_err !== 1'b0 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: valid=%b ovf=%0d aerr=%b last=%b required 0/0/0/0",
                     out_valid, overflow_count, align_err, out_last);
        end
    endtask

    task automatic test_basic_frame();
        logic [31:0] xs [5];
        logic [31:0] ys [5];
        xs[0] = 32'h000c8000; ys[0] = 32'h00032e66;
        for (int i = 1; i < 5; i++) begin xs[i] = px(i); ys[i] = ~px(i); end
        test_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, i == 0, xs[i], ys[i]);
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_x !== xs[i] || out_y !== ys[i] || out_idx !== 8'(i) ||
                out_frame !== 16'd0 || out_last !== (i == 4)) begin
                n_fail++;
                $display("FAIL basic[%0d]: v=%b x=%h y=%h idx=%0d fr=%0d last=%b required 1 %h %h %0d 0 %b",
                         i, out_valid, out_x, out_y, out_idx, out_frame, out_last, xs[i], ys[i], i, i == 4);
            end
        end
        drive(1'b0, 1'b0, '0, '0);
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_drain: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_sync();
        test_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, px(40 + i), px(50 + i));
            tick();
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL sync_ignore[%0d]: out_valid=%b required 0", i, out_valid);
            end
        end
        drive(1'b0, 1'b1, px(60), px(61));
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sync_first_no_valid: out_valid=%b required 0", out_valid);
        end
        drive(1'b1, 1'b1, px(7), px(8));
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_x !== px(7) || out_idx !== 8'd0 || out_frame !== 16'd0) begin
            n_fail++;
            $display("FAIL sync_first: v=%b x=%h idx=%0d fr=%0d required 1 %h 0 0",
                     out_valid, out_x, out_idx, out_frame, px(7));
        end
        drive(1'b0, 1'b0, '0, '0);
        tick();
    endtask

    task automatic test_overflow();
        test_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, k == 0, px(k), ~px(k));
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_x !== px(0) || out_idx !== 8'd0) begin
                n_fail++;
                $display("FAIL ovf_head[%0d]: v=%b x=%h idx=%0d required 1 %h 0", k, out_valid, out_x, out_idx, px(0));
            end
        end
        drive(1'b0, 1'b0, '0, '0);
        n_checks++;
        if (overflow_count !== 16'd4) begin
            n_fail++;
            $display("FAIL ovf_count: got %0d required 4", overflow_count);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_x !== px(k) || out_y !== ~px(k) ||
                out_idx !== 8'(k % 5) || out_frame !== 16'(k / 5) || out_last !== (k % 5 == 4)) begin
                n_fail++;
                $display("FAIL ovf_drain[%0d]: v=%b x=%h idx=%0d fr=%0d last=%b required 1 %h %0d %0d %b",
                         k, out_valid, out_x, out_idx, out_frame, out_last, px(k), k % 5, k / 5, k % 5 == 4);
            end
            tick();
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_empty: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_full_push_pop();
        int cnt;
        test_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, k == 0, px(k), ~px(k));
            tick();
        end
        out_ready = 1'b1;
        drive(1'b1, 1'b0, px(8), ~px(8));
        tick();
        n_checks++;
        if (overflow_count !== 16'd0 || out_x !== px(1)) begin
            n_fail++;
            $display("FAIL full_pushpop: ovf=%0d head=%h required 0 %h", overflow_count, out_x, px(1));
        end
        out_ready = 1'b0;
        drive(1'b1, 1'b0, px(9), ~px(9));
        tick();
        n_checks++;
        if (overflow_count !== 16'd1) begin
            n_fail++;
            $display("FAIL full_still_full: ovf=%0d required 1", overflow_count);
        end
        drive(1'b0, 1'b0, '0, '0);
        out_ready = 1'b1;
        cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_x !== px(k) || out_idx !== 8'(k % 5) || out_frame !== 16'(k / 5)) begin
                n_fail++;
                $display("FAIL full_drain[%0d]: v=%b x=%h idx=%0d fr=%0d required 1 %h %0d %0d",
                         k, out_valid, out_x, out_idx, out_frame, px(k), k % 5, k / 5);
            end
            if (out_valid === 1'b1) cnt++;
            tick();
        end
        n_checks++;
        if (out_valid !== 1'b0 || cnt != 8) begin
            n_fail++;
            $display("FAIL full_occupancy: entries=%0d trailing_valid=%b required 8 0", cnt, out_valid);
        end
    endtask

    task automatic test_align();
        logic [7:0]  e_idx [4];
        logic [15:0] e_fr  [4];
        logic        e_f   [4];
        e_idx[0] = 8'd0; e_fr[0] = 16'd0; e_f[0] = 1'b1;
        e_idx[1] = 8'd1; e_fr[1] = 16'd0; e_f[1] = 1'b0;
        e_idx[2] = 8'd0; e_fr[2] = 16'd1; e_f[2] = 1'b1;
        e_idx[3] = 8'd1; e_fr[3] = 16'd1; e_f[3] = 1'b0;
        test_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, e_f[i], px(20 + i), ~px(20 + i));
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_x !== px(20 + i) || out_idx !== e_idx[i] ||
                out_frame !== e_fr[i] || out_last !== 1'b0 || align_err !== (i >= 2)) begin
                n_fail++;
                $display("FAIL align[%0d]: v=%b x=%h idx=%0d fr=%0d last=%b aerr=%b required 1 %h %0d %0d 0 %b",
                         i, out_valid, out_x, out_idx, out_frame, out_last, align_err,
                         px(20 + i), e_idx[i], e_fr[i], i >= 2);
            end
        end
        drive(1'b0, 1'b0, '0, '0);
        tick();
    endtask

    task automatic test_reset_midstream();
        test_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, i != 1, px(30 + i), ~px(30 + i));
            tick();
        end
        drive(1'b0, 1'b0, '0, '0);
        n_checks++;
        if (out_valid !== 1'b1 || align_err !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pre: v=%b aerr=%b required 1 1", out_valid, align_err);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || align_err !== 1'b0 || overflow_count !== 16'd0) begin
            n_fail++;
            $display("FAIL midreset_post: v=%b aerr=%b ovf=%0d required 0 0 0", out_valid, align_err, overflow_count);
        end
        out_ready = 1'b1;
        drive(1'b1, 1'b0, px(35), px(36));
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_sync: out_valid=%b required 0", out_valid);
        end
        drive(1'b1, 1'b1, px(37), px(38));
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_x !== px(37) || out_idx !== 8'd0 || out_frame !== 16'd0) begin
            n_fail++;
            $display("FAIL midreset_restart: v=%b x=%h idx=%0d fr=%0d required 1 %h 0 0",
                     out_valid, out_x, out_idx, out_frame, px(37));
        end
        drive(1'b0, 1'b0, '0, '0);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 1'b0, '0, '0);
        test_basic_frame();
        test_sync();
        test_overflow();
        test_full_push_pop();
        test_align();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
